// File: rtl/wash_sequencer.sv
// Wash-cycle controller: walks fill/wash/drain/rinse/spin phases driven by the
// wash timer's timeout flags, with lid-open pause/resume and a configurable rinse count.
module wash_sequencer #(
    parameter int RINSES = 1
) (
    input  logic       clk,
    input  logic       R,
    input  logic       start,
    input  logic       lid,
    input  logic [1:0] load,
    input  logic       Td,
    input  logic       Tf,
    input  logic       Tr,
    input  logic       Ts,
    input  logic       Tw,
    output logic       R_timer,
    output logic [1:0] load_t,
    output logic       fill_valve,
    output logic       drain_valve,
    output logic       agitate,
    output logic       spin,
    output logic       lock,
    output logic       done,
    output logic       err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FILL  = 4'd1,
        S_WASH  = 4'd2,
        S_DRAIN = 4'd3,
        S_RFILL = 4'd4,
        S_RINSE = 4'd5,
        S_SPIN  = 4'd6,
        S_DONE  = 4'd7,
        S_PAUSE = 4'd8
    } state_t;

    state_t     cur, nxt, saved, saved_nxt;
    logic [1:0] load_q, load_nxt;
    logic [1:0] rinse_cnt, rinse_nxt;
    logic       active;
    logic       err_raw;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            cur       <= S_IDLE;
            saved     <= S_IDLE;
            load_q    <= 2'b00;
            rinse_cnt <= 2'd0;
        end else begin
            cur       <= nxt;
            saved     <= saved_nxt;
            load_q    <= load_nxt;
            rinse_cnt <= rinse_nxt;
        end
    end

    assign active = (cur == S_FILL) || (cur == S_WASH) || (cur == S_DRAIN) ||
                    (cur == S_RFILL) || (cur == S_RINSE) || (cur == S_SPIN);

    always_comb begin
        nxt       = cur;
        saved_nxt = saved;
        load_nxt  = load_q;
        rinse_nxt = rinse_cnt;
        err_raw   = 1'b0;
        // Lid wins over any same-cycle timer flag; the interrupted phase restarts on resume.
        if (active && lid) begin
            nxt       = S_PAUSE;
            saved_nxt = cur;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (start) begin
                        if (load == 2'b11) begin
                            err_raw = 1'b1;
                        end else if (!lid) begin
                            nxt       = S_FILL;
                            load_nxt  = load;
                            rinse_nxt = 2'(RINSES);
                        end
                    end
                end
                S_FILL:  if (Tf) nxt = S_WASH;
                S_WASH:  if (Tw) nxt = S_DRAIN;
                S_DRAIN: if (Td) nxt = (rinse_cnt != 2'd0) ? S_RFILL : S_SPIN;
                S_RFILL: if (Tf) nxt = S_RINSE;
                S_RINSE: begin
                    if (Tr) begin
                        nxt       = S_DRAIN;
                        rinse_nxt = rinse_cnt - 2'd1;
                    end
                end
                S_SPIN:  if (Ts) nxt = S_DONE;
                S_DONE:  if (!start) nxt = S_IDLE;
                S_PAUSE: if (!lid) nxt = saved;
                default: nxt = S_IDLE;
            endcase
        end
    end

    // Timer held clear while idle/paused and on every state change, so each phase counts from 0.
    assign R_timer     = (cur == S_IDLE) || (cur == S_DONE) || (cur == S_PAUSE) || (nxt != cur);
    assign err         = err_raw && !R;
    assign load_t      = load_q;
    assign fill_valve  = (cur == S_FILL) || (cur == S_RFILL);
    assign agitate     = (cur == S_WASH) || (cur == S_RINSE);
    assign drain_valve = (cur == S_DRAIN) || (cur == S_SPIN);
    assign spin        = (cur == S_SPIN);
    assign done        = (cur == S_DONE);
    assign lock        = active;
    assign state       = cur;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench: three sequencers (RINSES = 1, 0, 3) share stimulus, each paired
// with a behavioural wash timer whose flags fire at fixed counts per phase.
module tb_wash_sequencer;

    logic clk = 1'b0;
    logic R, start, lid;
    logic [1:0] load;

    logic [2:0]       td, tf, tr, ts, tw;
    logic [2:0]       rt, fv, dv, ag, sp, lk, dn, er;
    logic [2:0][1:0]  lt;
    logic [2:0][3:0]  st;

    int errors = 0;
    int checks = 0;
    int edge_no = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RV = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        int cnt = 0;

        // Timer: clears on R_timer, otherwise counts; phase lengths FILL 3, WASH 3/5/9, DRAIN 2, RINSE 5, SPIN 8.
        always_ff @(posedge clk) cnt <= rt[g] ? 0 : cnt + 1;

        assign tf[g] = (cnt == 2);
        assign td[g] = (cnt == 1);
        assign tr[g] = (cnt == 4);
        assign ts[g] = (cnt == 7);
        assign tw[g] = (cnt == ((lt[g] == 2'd0) ? 2 : (lt[g] == 2'd1) ? 4 : 8));

        wash_sequencer #(.RINSES(RV)) u_dut (
            .clk(clk), .R(R), .start(start), .lid(lid), .load(load),
            .Td(td[g]), .Tf(tf[g]), .Tr(tr[g]), .Ts(ts[g]), .Tw(tw[g]),
            .R_timer(rt[g]), .load_t(lt[g]), .fill_valve(fv[g]), .drain_valve(dv[g]),
            .agitate(ag[g]), .spin(sp[g]), .lock(lk[g]), .done(dn[g]), .err(er[g]),
            .state(st[g])
        );
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic to_edge(input int e);
        while (edge_no < e) begin
            @(posedge clk);
            edge_no++;
        end
        #1;
    endtask

    task automatic do_reset();
        R = 1'b1; start = 1'b0; lid = 1'b0; load = 2'b00;
        @(posedge clk);
        #1;
        R = 1'b0;
        edge_no = 0;
    endtask

    // {fill, drain, agitate, spin, lock}
    function automatic int act(input int g);
        return int'({fv[g], dv[g], ag[g], sp[g], lk[g]});
    endfunction

    initial begin
        int drains, rinses, prev;
        R = 1'b1; start = 1'b0; lid = 1'b0; load = 2'b00;
        #2;
        chk("rst_state", st[0], 0);
        chk("rst_rtimer", rt[0], 1);
        chk("rst_act", act(0), 0);
        chk("rst_done_err", {dn[0], er[0]}, 0);
        chk("rst_load_t", lt[0], 0);

        // Nominal small load, one rinse
        do_reset();
        start = 1'b1; load = 2'b00;
        to_edge(1);
        chk("nom_fill", st[0], 1);
        chk("nom_fill_act", act(0), 5'b10001);
        chk("nom_fill_rt", rt[0], 0);
        to_edge(3);  chk("nom_fill_end", st[0], 1);
        to_edge(4);  chk("nom_wash", st[0], 2);
        chk("nom_wash_act", act(0), 5'b00101);
        load = 2'b10;
        to_edge(7);  chk("nom_drain", st[0], 3);
        chk("nom_drain_act", act(0), 5'b01001);
        chk("nom_load_held", lt[0], 0);
        to_edge(9);  chk("nom_rfill", st[0], 4);
        to_edge(12); chk("nom_rinse", st[0], 5);
        to_edge(17); chk("nom_drain2", st[0], 3);
        to_edge(19); chk("nom_spin", st[0], 6);
        chk("nom_spin_act", act(0), 5'b01011);
        to_edge(26); chk("nom_spin_end", st[0], 6);
        to_edge(27); chk("nom_done", st[0], 7);
        chk("nom_done_out", dn[0], 1);
        chk("nom_done_act", act(0), 0);
        to_edge(28); chk("nom_done_hold", st[0], 7);
        start = 1'b0;
        to_edge(29); chk("nom_idle", st[0], 0);

        // No rinse, medium load
        do_reset();
        start = 1'b1; load = 2'b01;
        to_edge(4);  chk("med_wash", st[1], 2);
        to_edge(8);  chk("med_wash_end", st[1], 2);
        to_edge(9);  chk("med_drain", st[1], 3);
        to_edge(11); chk("med_spin", st[1], 6);
        to_edge(18); chk("med_spin_end", st[1], 6);
        to_edge(19); chk("med_done", dn[1], 1);

        // No rinse, large load
        do_reset();
        start = 1'b1; load = 2'b10;
        to_edge(12); chk("lrg_wash_end", st[1], 2);
        to_edge(13); chk("lrg_drain", st[1], 3);
        to_edge(22); chk("lrg_spin_end", st[1], 6);
        to_edge(23); chk("lrg_done", dn[1], 1);

        // Illegal load
        do_reset();
        start = 1'b1; load = 2'b11;
        #1;
        chk("ill_err", er[0], 1);
        chk("ill_state", st[0], 0);
        chk("ill_act", act(0), 0);
        to_edge(1);  chk("ill_stay", st[0], 0);
        load = 2'b00;
        #1;
        chk("ill_err_clr", er[0], 0);
        to_edge(2);  chk("ill_fill", st[0], 1);

        // Lid opened during WASH cycle 2
        do_reset();
        start = 1'b1; load = 2'b00;
        to_edge(5);  chk("pw_wash", st[0], 2);
        lid = 1'b1;
        to_edge(6);  chk("pw_pause", st[0], 8);
        chk("pw_act", act(0), 0);
        chk("pw_rt", rt[0], 1);
        to_edge(9);  chk("pw_pause_hold", st[0], 8);
        lid = 1'b0;
        to_edge(10); chk("pw_resume", st[0], 2);
        to_edge(12); chk("pw_wash_full", st[0], 2);
        to_edge(13); chk("pw_drain", st[0], 3);
        to_edge(32); chk("pw_spin_end", st[0], 6);
        to_edge(33); chk("pw_done", dn[0], 1);

        // Lid opens in the same cycle Tf fires in FILL
        do_reset();
        start = 1'b1; load = 2'b00;
        to_edge(3);
        lid = 1'b1;
        to_edge(4);  chk("pf_pause", st[0], 8);
        lid = 1'b0;
        to_edge(5);  chk("pf_fill", st[0], 1);
        to_edge(7);  chk("pf_fill_full", st[0], 1);
        to_edge(8);  chk("pf_wash", st[0], 2);

        // Asynchronous reset mid-SPIN
        do_reset();
        start = 1'b1; load = 2'b00;
        to_edge(20); chk("ar_spin", st[0], 6);
        #2;
        R = 1'b1;
        #1;
        chk("ar_act", act(0), 0);
        chk("ar_state", st[0], 0);
        chk("ar_rt", rt[0], 1);
        @(posedge clk);
        #1;
        R = 1'b0;
        edge_no = 0;
        to_edge(1);  chk("ar_refill", st[0], 1);

        // Three rinses
        do_reset();
        start = 1'b1; load = 2'b00;
        drains = 0; rinses = 0; prev = 0;
        for (int e = 1; e <= 47; e++) begin
            to_edge(e);
            if (st[2] != prev && st[2] == 3) drains++;
            if (st[2] != prev && st[2] == 5) rinses++;
            prev = st[2];
            if (e == 46) chk("r3_spin_end", st[2], 6);
        end
        chk("r3_drains", drains, 4);
        chk("r3_rinses", rinses, 3);
        chk("r3_done", st[2], 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Wash-cycle controller FSM for the washing machine controller.
- Sits directly downstream of the wash timer: consumes its timeout flags (Td, Tf, Tr, Ts, Tw) and drives back the timer clear and the latched load size.
- Drives the valve, motor and lock actuators.
- Supports a configurable rinse count and lid-open pause/resume.

Parameters:
RINSES, 1, number of rinse passes after the wash (legal 0..3)

Ports:
clk  input  1  system clock
R  input  1  reset; asynchronous, active-high
start  input  1  user start request; level-sensitive
lid  input  1  1 = lid open
load  input  2  load size selector (00 small, 01 medium, 10 large, 11 illegal)
Td  input  1  timer drain timeout
Tf  input  1  timer fill timeout
Tr  input  1  timer rinse timeout
Ts  input  1  timer spin timeout
Tw  input  1  timer wash timeout
R_timer  output  1  synchronous clear to timer counter
load_t  output  2  latched load size to timer
fill_valve  output  1  water inlet open
drain_valve  output  1  drain pump on
agitate  output  1  agitator motor on
spin  output  1  spin motor on
lock  output  1  lid lock engaged
done  output  1  cycle complete
err  output  1  illegal load at start
state  output  4  current state code (debug)

Behaviour:
- Reset is asynchronous and active-high:
  - On R=1: state=IDLE, load_q=00, rinse_cnt=0, saved state=IDLE.
  - Outputs during and after reset: R_timer=1; all actuator outputs, done and err = 0.
- State codes: IDLE 0, FILL 1, WASH 2, DRAIN 3, RFILL 4, RINSE 5, SPIN 6, DONE 7, PAUSE 8. Codes 9-15 recover to IDLE on the next edge.
- Outputs are Moore-decoded from the registered state:
  - FILL/RFILL: fill_valve
  - WASH/RINSE: agitate
  - DRAIN: drain_valve
  - SPIN: spin and drain_valve
  - DONE: done
  - lock=1 in FILL..SPIN; 0 in IDLE, DONE and PAUSE.
- R_timer (combinational):
  - 1 in IDLE, DONE and PAUSE.
  - 1 in any cycle where next_state != state.
  - Otherwise 0.
  - Result: the timer counter reads 0 in the first cycle of every state. A state exiting on a flag that fires at count k lasts k+1 cycles.
- Transitions (only the listed flag is honoured per state; other flags are ignored):
  - IDLE -> FILL when start=1 & lid=0 & load!=11. On this transition, latch load into load_q and set rinse_cnt=RINSES.
  - IDLE with start=1 & load=11: err=1 (combinational), stay in IDLE.
  - FILL -> WASH on Tf.
  - WASH -> DRAIN on Tw.
  - DRAIN on Td: go to RFILL if rinse_cnt!=0, else SPIN.
  - RFILL -> RINSE on Tf.
  - RINSE -> DRAIN on Tr; decrement rinse_cnt on this transition.
  - SPIN -> DONE on Ts.
  - DONE -> IDLE when start=0. No auto-restart while start is held.
- Pause:
  - In FILL..SPIN, lid=1 saves the current state and moves to PAUSE.
  - lid has priority over a timer flag arriving in the same cycle; the flag is lost and that state restarts on resume.
  - PAUSE -> saved state when lid=0. The timer restarts from 0 because R_timer is held high throughout PAUSE.
  - rinse_cnt and load_q are unchanged across PAUSE.
- load_t = load_q at all times. load changes after leaving IDLE have no effect.
- Reset mid-cycle: everything returns to IDLE immediately, with no drain or completion.

Test Plan:
- Nominal small load, RINSES=1: start=1, load=00 at cycle 0.
  - FILL entered at edge 1; phases last FILL 3, WASH 3, DRAIN 2, RFILL 3, RINSE 5, DRAIN 2, SPIN 8 cycles.
  - done=1 from edge 27; start=0 returns to IDLE on the next edge.
- Load sizes, RINSES=0: load=01 gives WASH 5 cycles; load=10 gives WASH 9 cycles.
  - DRAIN goes straight to SPIN.
  - done at edge 1+3+W+2+8, i.e. edge 19 for load=01 and edge 23 for load=10.
- Illegal load: start=1, load=11 -> err=1, state stays 0, all actuators 0. Changing load to 00 -> FILL on the next edge, err=0.
- Pause in WASH: lid=1 for 4 cycles at WASH cycle 2.
  - Result: state=8, agitate=0, lock=0, R_timer=1.
  - After lid=0, WASH re-entered with a full 3/5/9-cycle duration; overall done is delayed by 4 + elapsed WASH cycles.
  - Lid open in the same cycle as Tf in FILL -> PAUSE, then FILL repeats in full.
- Async reset: assert R mid-SPIN between clock edges -> spin, drain_valve and lock drop immediately; state=0, R_timer=1. start held high after release -> fresh FILL.
- RINSES=3: DRAIN visited 4 times, RINSE 3 times; rinse_cnt reaches 0 before SPIN.
